// File: rtl/pulse_buf_pkg.sv
// pulse_buf_pkg: shared widths, depth defaults and entry-width helper for the pulse command buffer.
// PULSE_BUF_TIMESTAMP_EN appends a capture timestamp to every entry.
package pulse_buf_pkg;
    localparam int PULSE_CMD_WIDTH = 72;
    localparam int DEF_DEPTH_LOG2  = 3;
    localparam int DEF_TS_WIDTH    = 32;
`ifdef PULSE_BUF_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    function automatic int entry_width(input int cmd_w, input int ts_w, input bit ts_en);
        return ts_en ? cmd_w + ts_w : cmd_w;
    endfunction
endpackage

// File: rtl/pulse_buf_mem.sv
// pulse_buf_mem: 2^AW-entry register array, one synchronous write port and one asynchronous read port.
module pulse_buf_mem #(
    parameter int W  = 72,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [2**AW];
    // storage is never reset; occupancy tracking lives in the owner
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pulse_cmd_buf.sv
// pulse_cmd_buf: elastic FIFO between core pulse-command strobes and a valid/ready consumer.
// Head entry is held in a register (first-word-fall-through, 1-cycle latency); count includes the head.
// Define PULSE_BUF_TIMESTAMP_EN to tag each entry with a free-running capture timestamp.
module pulse_cmd_buf
    import pulse_buf_pkg::*;
#(
    parameter int CMD_WIDTH  = PULSE_CMD_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    localparam int W         = entry_width(CMD_WIDTH, TS_WIDTH, TS_EN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cstrobe,
    input  logic [CMD_WIDTH-1:0]  cmd_in,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] DEPTH = CW'(1) << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [DEPTH_LOG2:0]   r_count, w_count_next;
    logic [W-1:0]          r_out, w_entry, w_mem_rdata;
    logic                  r_valid, r_full, r_empty, r_ovf;
    logic                  w_pop, w_push, w_drop;

    assign w_pop        = r_valid & out_ready;
    assign w_push       = cstrobe & (~r_full | w_pop) & ~flush;
    assign w_drop       = cstrobe & r_full & ~w_pop & ~flush;
    assign w_rd_next    = r_rd_ptr + 1'b1;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef PULSE_BUF_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;
    // free-running capture clock, wraps naturally
    always_ff @(posedge clk or posedge reset)
        if (reset) r_ts <= '0;
        else r_ts <= r_ts + 1'b1;
    assign w_entry = {cmd_in, r_ts};
`else
    assign w_entry = cmd_in;
`endif

    pulse_buf_mem #(.W(W), .AW(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (w_rd_next),
        .o_rdata (w_mem_rdata)
    );

    // pointers, occupancy, flags and head register; flush overrides push/pop
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_out    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= w_rd_next;
            r_count <= w_count_next;
            r_valid <= w_count_next != '0;
            r_full  <= w_count_next == DEPTH;
            r_empty <= w_count_next == '0;
            // new word becomes head when the queue is (or is becoming) empty; otherwise the next stored entry moves up
            if (w_push && (!r_valid || (w_pop && r_count == CW'(1)))) r_out <= w_entry;
            else if (w_pop && r_count > CW'(1)) r_out <= w_mem_rdata;
        end

    // sticky overflow; a drop in the same cycle beats clear_err
    always_ff @(posedge clk or posedge reset)
        if (reset) r_ovf <= 1'b0;
        else r_ovf <= w_drop | (r_ovf & ~clear_err);

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_pulse_cmd_buf.sv
// tb_pulse_cmd_buf: directed self-checking bench for pulse_cmd_buf.
module tb_pulse_cmd_buf;
    import pulse_buf_pkg::*;
    localparam int W = entry_width(PULSE_CMD_WIDTH, DEF_TS_WIDTH, TS_EN);

    logic         clk = 1'b0, reset = 1'b1, cstrobe = 1'b0, flush = 1'b0, clear_err = 1'b0, out_ready = 1'b0;
    logic [71:0]  cmd_in = '0;
    logic [W-1:0] out_data;
    logic         out_valid, full, empty, overflow;
    logic [3:0]   count;
    logic [71:0]  head;
    int           n_pass = 0, n_total = 0;

    assign head = out_data[W-1 -: 72];

    pulse_cmd_buf dut (
        .clk(clk), .reset(reset), .cstrobe(cstrobe), .cmd_in(cmd_in), .flush(flush),
        .clear_err(clear_err), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int base);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            cstrobe = 1'b1; cmd_in = 72'(base + i); tick;
        end
        cstrobe = 1'b0;
    endtask

    task automatic test_reset;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL rst_full got %b exp 0", full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rst_data got %h exp 0", out_data); else n_pass++;
    endtask

    task automatic test_single;
        cstrobe = 1'b1; cmd_in = 72'hA5; out_ready = 1'b1; tick;
        cstrobe = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (head !== 72'hA5) $display("FAIL single_data got %h exp a5", head); else n_pass++;
        n_total++; if (count !== 4'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
        tick;
        out_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL single_empty got %b exp 1", empty); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL single_count0 got %0d exp 0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_valid0 got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow;
        fill(8, 1);
        n_total++; if (full !== 1'b1) $display("FAIL ovf_full got %b exp 1", full); else n_pass++;
        n_total++; if (count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else n_pass++;
        cstrobe = 1'b1; cmd_in = 72'd9; tick;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else n_pass++;
        n_total++; if (count !== 4'd8) $display("FAIL ovf_count_hold got %0d exp 8", count); else n_pass++;
        n_total++; if (head !== 72'd1) $display("FAIL ovf_head got %h exp 1", head); else n_pass++;
        cmd_in = 72'd10; clear_err = 1'b1; tick;
        cstrobe = 1'b0; clear_err = 1'b0;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", overflow); else n_pass++;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || head !== 72'(i)) $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, head, 72'(i));
            else n_pass++;
            tick;
        end
        out_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL ovf_drained got %b exp 1", empty); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else n_pass++;
        clear_err = 1'b1; tick;
        clear_err = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop;
        fill(8, 1);
        cstrobe = 1'b1; cmd_in = 72'd9; out_ready = 1'b1; tick;
        cstrobe = 1'b0; out_ready = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got %b exp 0", overflow); else n_pass++;
        n_total++; if (count !== 4'd8) $display("FAIL fpp_count got %0d exp 8", count); else n_pass++;
        n_total++; if (full !== 1'b1) $display("FAIL fpp_full got %b exp 1", full); else n_pass++;
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || head !== 72'(i)) $display("FAIL fpp_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, head, 72'(i));
            else n_pass++;
            tick;
        end
        out_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL fpp_empty got %b exp 1", empty); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [39:0] stall_pat;
        logic [71:0] q[$];
        logic [71:0] prev_data;
        logic        prev_stall, pop, push;
        int          issued, received, c;
        stall_pat = 40'h00_2461_8C30;
        issued = 0; received = 0; c = 0; prev_stall = 1'b0; prev_data = '0;
        while ((issued < 20 || q.size() > 0) && c < 80) begin
            cstrobe = issued < 20;
            cmd_in = 72'h40 + 72'(issued);
            out_ready = c < 40 ? ~stall_pat[c] : 1'b1;
            n_total++;
            if (q.size() > 0 ? (out_valid !== 1'b1 || head !== q[0]) : (out_valid !== 1'b0))
                $display("FAIL b2b_head c=%0d got v=%b d=%h exp n=%0d d=%h", c, out_valid, head, q.size(), q.size() > 0 ? q[0] : 72'h0);
            else n_pass++;
            if (prev_stall) begin
                n_total++; if (head !== prev_data) $display("FAIL b2b_stable c=%0d got %h exp %h", c, head, prev_data); else n_pass++;
            end
            pop = q.size() > 0 && out_ready;
            push = cstrobe && (q.size() < 8 || pop);
            prev_stall = q.size() > 0 && !out_ready;
            prev_data = head;
            tick;
            if (pop) begin void'(q.pop_front()); received++; end
            if (push) q.push_back(cmd_in);
            if (cstrobe) issued++;
            n_total++; if (count !== 4'(q.size())) $display("FAIL b2b_count c=%0d got %0d exp %0d", c, count, q.size()); else n_pass++;
            c++;
        end
        cstrobe = 1'b0; out_ready = 1'b0;
        n_total++; if (received !== 20) $display("FAIL b2b_received got %0d exp 20", received); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_flush;
        fill(5, 72'h10);
        n_total++; if (count !== 4'd5) $display("FAIL flush_pre got %0d exp 5", count); else n_pass++;
        flush = 1'b1; cstrobe = 1'b1; cmd_in = 72'hFF; tick;
        flush = 1'b0; cstrobe = 1'b0;
        n_total++; if (count !== 4'd0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b exp 0", overflow); else n_pass++;
        fill(8, 72'h20);
        flush = 1'b1; cstrobe = 1'b1; cmd_in = 72'hFE; tick;
        flush = 1'b0; cstrobe = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL flush_full_ovf got %b exp 0", overflow); else n_pass++;
        n_total++; if (full !== 1'b0 || empty !== 1'b1) $display("FAIL flush_flags got f=%b e=%b exp f=0 e=1", full, empty); else n_pass++;
        fill(2, 72'h33);
        n_total++; if (head !== 72'h33 || count !== 4'd2) $display("FAIL flush_refill got d=%h n=%0d exp d=33 n=2", head, count); else n_pass++;
        out_ready = 1'b1; tick;
        n_total++; if (head !== 72'h34) $display("FAIL flush_refill2 got %h exp 34", head); else n_pass++;
        tick; out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        fill(3, 72'h50);
        cstrobe = 1'b1; cmd_in = 72'h77;
        #2 reset = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0 || count !== 4'd0) $display("FAIL arst_state got v=%b n=%0d exp v=0 n=0", out_valid, count); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) $display("FAIL arst_flags got e=%b f=%b o=%b exp 1 0 0", empty, full, overflow); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL arst_data got %h exp 0", out_data); else n_pass++;
        cstrobe = 1'b0;
        @(negedge clk) reset = 1'b0;
        tick; tick; tick;
        cstrobe = 1'b1; cmd_in = 72'hC3; tick;
        cstrobe = 1'b0; tick; tick; tick;
        cstrobe = 1'b1; cmd_in = 72'hC7; tick;
        cstrobe = 1'b0;
        n_total++; if (head !== 72'hC3 || count !== 4'd2) $display("FAIL ts_first got d=%h n=%0d exp d=c3 n=2", head, count); else n_pass++;
`ifdef PULSE_BUF_TIMESTAMP_EN
        n_total++; if (out_data[DEF_TS_WIDTH-1:0] !== 32'd3) $display("FAIL ts_3 got %0d exp 3", out_data[DEF_TS_WIDTH-1:0]); else n_pass++;
`endif
        out_ready = 1'b1; tick;
        out_ready = 1'b0;
        n_total++; if (head !== 72'hC7) $display("FAIL ts_second got %h exp c7", head); else n_pass++;
`ifdef PULSE_BUF_TIMESTAMP_EN
        n_total++; if (out_data[DEF_TS_WIDTH-1:0] !== 32'd7) $display("FAIL ts_7 got %0d exp 7", out_data[DEF_TS_WIDTH-1:0]); else n_pass++;
`endif
    endtask

    initial begin
        #12 reset = 1'b0;
        test_reset;
        test_single;
        test_overflow;
        test_full_push_pop;
        test_back_to_back;
        test_flush;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
